pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch-stage sequencer that sits directly upstream of the program memory.
- Holds the program counter and drives the program memory address combinationally from it.
- Latches the returned instruction into an instruction register for the decode stage.
- Supports relative branch, absolute jump, subroutine call/return on a small hardware return stack, stall, and halt/resume.

Parameters:
Psize, 6, program address width (memory depth 2^Psize).
Isize, 24, instruction MSB index; instruction width is Isize+1.
Sdepth, 4, return-stack entries (power of two, ≥2).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
address  out  Psize  program memory address; equals pc combinationally.
instr  in  Isize+1  instruction returned by program memory for address.
stall  in  1  hold pc and ir this cycle.
branch_en  in  1  pc <= pc + branch_off.
branch_off  in  Psize  signed two's-complement branch offset.
jump_en  in  1  pc <= target.
call_en  in  1  push pc+1; pc <= target.
ret_en  in  1  pop return address into pc.
target  in  Psize  absolute jump/call address.
halt_en  in  1  enter HALT.
resume  in  1  leave HALT.
ir  out  Isize+1  registered instruction.
ir_pc  out  Psize  address ir was fetched from.
ir_valid  out  1  ir holds a fresh fetch.
halted  out  1  state == HALT.
stk_ovf  out  1  sticky overflow flag.
stk_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (async, active-high): pc=0, sp=0, state=RUN, ir=0, ir_pc=0, ir_valid=0, stk_ovf=0, stk_unf=0, stack contents=0.
- Memory is combinational: address=pc; instr is valid in the same cycle.
- State RUN, each rising edge with stall=0:
  - ir<=instr, ir_pc<=pc, ir_valid<=1.
  - pc updates by priority: halt_en > ret_en > call_en > jump_en > branch_en > pc+1.
- halt_en: pc holds; state<=HALT; ir is still captured at that edge.
- ret_en:
  - sp≠0: pc<=stack[sp-1], sp<=sp-1.
  - sp==0: pc<=pc+1, stk_unf<=1.
- call_en:
  - sp<Sdepth: stack[sp]<=pc+1, sp<=sp+1, pc<=target.
  - sp==Sdepth: no push, pc<=pc+1, stk_ovf<=1.
- jump_en: pc<=target.
- branch_en: pc<=pc+sign-extended branch_off, modulo 2^Psize.
- Increment: pc+1 wraps from 2^Psize-1 to 0. A pushed return address wraps the same way.
- Stall in RUN: pc, sp, stack, ir and ir_pc hold; ir_valid<=0; all control inputs are ignored.
- State HALT:
  - pc, sp, ir and ir_pc hold; ir_valid<=0; halted=1.
  - Control inputs and stall are ignored.
  - resume=1: state<=RUN at that edge; fetch restarts at the held pc on the next edge.
- Simultaneous halt_en and resume in RUN: halt wins.
- stk_ovf and stk_unf are sticky until reset.
- Reset asserted mid-operation clears everything immediately, independent of clk.
- No multicycle paths; pc-to-address is the only combinational output path.

Decomposition:
- Package pc_seq_pkg holds:
  - state enum {RUN, HALT};
  - the priority-select encoding enum {NXT_INC, NXT_BR, NXT_JMP, NXT_CALL, NXT_RET, NXT_HOLD};
  - localparam for instruction width (Isize+1).
- One sub-module, ret_stack:
  - Sdepth x Psize LIFO with push, pop, full and empty;
  - push when full and pop when empty are suppressed internally;
  - same async active-high reset.
- Top level holds the FSM, next-pc mux and ir register.

Test Plan:
- Reset then 5 free-running cycles with memory preloaded mem[i]=i:
  - address goes 0,1,2,3,4;
  - ir_pc lags by one cycle;
  - ir_valid=1 from the first edge.
- pc=10, branch_en with branch_off=6'h3C (-4) → pc=6; pc=63 with no control → pc=0 (wrap).
- pc=5, call_en target=20 → pc=20, sp=1, stack[0]=6; later ret_en → pc=6, sp=0.
- Five nested calls with Sdepth=4:
  - 5th call → pc=prev+1, stk_ovf=1, sp=4;
  - five rets → 4 pops, 5th sets stk_unf=1.
- stall=1 for 3 cycles at pc=8 with jump_en=1 → pc stays 8, ir_valid=0; stall drops with jump_en=1, target=30 → pc=30.
- halt_en at pc=12 → halted=1, pc=12 for 4 cycles; resume → RUN; next edge ir_pc=12, pc=13. Assert reset mid-HALT → all outputs zero asynchronously.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and defaults for the fetch-stage pc sequencer
package pc_seq_pkg;

  localparam int PSIZE_DEF  = 6;
  localparam int ISIZE_DEF  = 24;
  localparam int SDEPTH_DEF = 4;
  localparam int IWIDTH     = ISIZE_DEF + 1;

  typedef enum logic {
    RUN,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    NXT_INC,
    NXT_BR,
    NXT_JMP,
    NXT_CALL,
    NXT_RET,
    NXT_HOLD
  } nxt_sel_t;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// rtl/pc_sequencer_ret_stack.sv - hardware return-address LIFO for subroutine call/return
module ret_stack #(
  parameter int Psize  = 6,
  parameter int Sdepth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Psize-1:0] din,
  output logic [Psize-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(Sdepth);

  logic [AW:0]      sp;
  logic [Psize-1:0] mem [Sdepth];
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = wr_idx - AW'(1);
  assign full   = (sp == (AW+1)'(Sdepth));
  assign empty  = (sp == '0);
  // top of stack is read combinationally so a return completes in one edge
  assign dout   = mem[rd_idx];

  // push into the next free slot or pop the top; overflow/underflow requests are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= '0;
      for (int i = 0; i < Sdepth; i++) mem[i] <= '0;
    end else if (push && !full) begin
      mem[wr_idx] <= din;
      sp          <= sp + (AW+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage sequencer: program counter, next-pc select, instruction register
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int Psize  = PSIZE_DEF,
  parameter int Isize  = IWIDTH - 1,
  parameter int Sdepth = SDEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic [Psize-1:0] address,
  input  logic [Isize:0]   instr,
  input  logic             stall,
  input  logic             branch_en,
  input  logic [Psize-1:0] branch_off,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [Psize-1:0] target,
  input  logic             halt_en,
  input  logic             resume,
  output logic [Isize:0]   ir,
  output logic [Psize-1:0] ir_pc,
  output logic             ir_valid,
  output logic             halted,
  output logic             stk_ovf,
  output logic             stk_unf
);

  state_t           state;
  nxt_sel_t         sel;
  logic [Psize-1:0] pc;
  logic [Psize-1:0] pc_inc;
  logic [Psize-1:0] pc_next;
  logic [Psize-1:0] stk_top;
  logic             run_fetch;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic             ovf_evt;
  logic             unf_evt;

  assign address   = pc;
  assign halted    = (state == HALT);
  assign pc_inc    = pc + Psize'(1);
  assign run_fetch = (state == RUN) && !stall;

  // resolve the control inputs by priority; a failed call/return falls back to increment
  always_comb begin
    sel     = NXT_INC;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (!run_fetch || halt_en) begin
      sel = NXT_HOLD;
    end else if (ret_en) begin
      pop = 1'b1;
      if (empty) unf_evt = 1'b1;
      else       sel     = NXT_RET;
    end else if (call_en) begin
      push = 1'b1;
      if (full) ovf_evt = 1'b1;
      else      sel     = NXT_CALL;
    end else if (jump_en) begin
      sel = NXT_JMP;
    end else if (branch_en) begin
      sel = NXT_BR;
    end
  end

  // next-pc mux; the branch add wraps modulo 2^Psize so sign extension is implicit
  always_comb begin
    case (sel)
      NXT_BR:            pc_next = pc + branch_off;
      NXT_JMP, NXT_CALL: pc_next = target;
      NXT_RET:           pc_next = stk_top;
      NXT_HOLD:          pc_next = pc;
      default:           pc_next = pc_inc;
    endcase
  end

  ret_stack #(
    .Psize  (Psize),
    .Sdepth (Sdepth)
  ) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (full),
    .empty (empty)
  );

  // run/halt state machine with pc, instruction register and sticky stack flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
    end else begin
      pc <= pc_next;
      case (state)
        RUN: begin
          if (stall) begin
            ir_valid <= 1'b0;
          end else begin
            ir       <= instr;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (halt_en) state <= HALT;
            if (ovf_evt) stk_ovf <= 1'b1;
            if (unf_evt) stk_unf <= 1'b1;
          end
        end
        default: begin
          ir_valid <= 1'b0;
          if (resume) state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  address;
  logic [24:0] instr;
  logic        stall, branch_en, jump_en, call_en, ret_en, halt_en, resume;
  logic [5:0]  branch_off, target;
  logic [24:0] ir;
  logic [5:0]  ir_pc;
  logic        ir_valid, halted, stk_ovf, stk_unf;

  logic [24:0] mem [64];

  int errors = 0;
  int checks = 0;

  // reference model state
  int          m_pc;
  int          m_stk[$];
  bit          m_halted;
  logic [24:0] m_ir;
  int          m_irpc;
  bit          m_valid, m_ovf, m_unf;

  pc_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .instr      (instr),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_off (branch_off),
    .jump_en    (jump_en),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .target     (target),
    .halt_en    (halt_en),
    .resume     (resume),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .halted     (halted),
    .stk_ovf    (stk_ovf),
    .stk_unf    (stk_unf)
  );

  always #5 clk = ~clk;

  // combinational program memory
  always_comb instr = mem[address];

  task automatic idle();
    stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
    halt_en = 0; resume = 0; branch_off = '0; target = '0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_stk.delete(); m_halted = 0; m_ir = '0; m_irpc = 0;
    m_valid = 0; m_ovf = 0; m_unf = 0;
  endtask

  // one clock edge of the architectural rules, evaluated on the inputs present at that edge
  task automatic model_edge();
    int off;
    if (m_halted) begin
      m_valid = 0;
      if (resume) m_halted = 0;
    end else if (stall) begin
      m_valid = 0;
    end else begin
      m_ir = mem[m_pc]; m_irpc = m_pc; m_valid = 1;
      if (halt_en) m_halted = 1;
      else if (ret_en) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % 64; m_unf = 1; end
      end else if (call_en) begin
        if (m_stk.size() < 4) begin m_stk.push_back((m_pc + 1) % 64); m_pc = int'(target); end
        else begin m_pc = (m_pc + 1) % 64; m_ovf = 1; end
      end else if (jump_en) m_pc = int'(target);
      else if (branch_en) begin
        off = int'(branch_off);
        if (off > 31) off -= 64;
        m_pc = (m_pc + off + 64) % 64;
      end else m_pc = (m_pc + 1) % 64;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #2;
    reset = 0;
    #1;
  endtask

  task automatic goto_pc(input int p);
    idle();
    jump_en = 1; target = 6'(p);
    tick();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    #2;
    checks++; if (address !== 6'd0)   begin errors++; $display("FAIL reset_address got=%0d exp=0", address); end
    checks++; if (ir !== 25'd0)       begin errors++; $display("FAIL reset_ir got=%0h exp=0", ir); end
    checks++; if (ir_pc !== 6'd0)     begin errors++; $display("FAIL reset_ir_pc got=%0d exp=0", ir_pc); end
    checks++; if (ir_valid !== 1'b0)  begin errors++; $display("FAIL reset_ir_valid got=%0b exp=0", ir_valid); end
    checks++; if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if ({stk_ovf, stk_unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {stk_ovf, stk_unf}); end
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 64; i++) mem[i] = 25'(i);
    @(posedge clk); #1;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      checks++; if (address !== 6'(k)) begin errors++; $display("FAIL free_run_address got=%0d exp=%0d", address, k); end
      tick();
      checks++; if (ir_pc !== 6'(k)) begin errors++; $display("FAIL free_run_ir_pc got=%0d exp=%0d", ir_pc, k); end
      checks++; if (ir !== 25'(k))   begin errors++; $display("FAIL free_run_ir got=%0d exp=%0d", ir, k); end
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL free_run_ir_valid got=%0b exp=1", ir_valid); end
    end
  endtask

  task automatic test_branch();
    goto_pc(10);
    branch_en = 1; branch_off = 6'h3C;
    tick(); idle();
    checks++; if (address !== 6'd6) begin errors++; $display("FAIL branch_back got=%0d exp=6", address); end
    goto_pc(63);
    tick();
    checks++; if (address !== 6'd0) begin errors++; $display("FAIL inc_wrap got=%0d exp=0", address); end
  endtask

  task automatic test_call_ret();
    goto_pc(5);
    call_en = 1; target = 6'd20;
    tick(); idle();
    checks++; if (address !== 6'd20) begin errors++; $display("FAIL call_target got=%0d exp=20", address); end
    tick();
    ret_en = 1;
    tick(); idle();
    checks++; if (address !== 6'd6) begin errors++; $display("FAIL ret_addr got=%0d exp=6", address); end
    checks++; if (ir_pc !== 6'd21) begin errors++; $display("FAIL ret_ir_pc got=%0d exp=21", ir_pc); end
  endtask

  task automatic test_overflow();
    int exp_ret[4] = '{31, 21, 11, 1};
    idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      call_en = 1; target = 6'((i + 1) * 10);
      tick();
      if (i < 4) begin
        checks++; if (address !== 6'((i + 1) * 10)) begin errors++; $display("FAIL nest_call%0d got=%0d exp=%0d", i, address, (i + 1) * 10); end
        checks++; if (stk_ovf !== 1'b0) begin errors++; $display("FAIL early_ovf%0d got=%0b exp=0", i, stk_ovf); end
      end else begin
        checks++; if (address !== 6'd41) begin errors++; $display("FAIL ovf_call got=%0d exp=41", address); end
        checks++; if (stk_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", stk_ovf); end
      end
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      ret_en = 1;
      tick();
      if (i < 4) begin
        checks++; if (address !== 6'(exp_ret[i])) begin errors++; $display("FAIL nest_ret%0d got=%0d exp=%0d", i, address, exp_ret[i]); end
        checks++; if (stk_unf !== 1'b0) begin errors++; $display("FAIL early_unf%0d got=%0b exp=0", i, stk_unf); end
      end else begin
        checks++; if (address !== 6'd2) begin errors++; $display("FAIL unf_ret got=%0d exp=2", address); end
        checks++; if (stk_unf !== 1'b1) begin errors++; $display("FAIL unf_flag got=%0b exp=1", stk_unf); end
      end
    end
    idle();
    tick();
    checks++; if (stk_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", stk_ovf); end
  endtask

  task automatic test_stall();
    goto_pc(8);
    stall = 1; jump_en = 1; target = 6'd30;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (address !== 6'd8) begin errors++; $display("FAIL stall_pc%0d got=%0d exp=8", i, address); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL stall_valid%0d got=%0b exp=0", i, ir_valid); end
    end
    stall = 0;
    tick(); idle();
    checks++; if (address !== 6'd30) begin errors++; $display("FAIL unstall_jump got=%0d exp=30", address); end
    checks++; if (ir_pc !== 6'd8)    begin errors++; $display("FAIL unstall_ir_pc got=%0d exp=8", ir_pc); end
    checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL unstall_valid got=%0b exp=1", ir_valid); end
  endtask

  task automatic test_halt();
    goto_pc(12);
    halt_en = 1;
    tick(); idle();
    checks++; if (halted !== 1'b1)  begin errors++; $display("FAIL halt_enter got=%0b exp=1", halted); end
    checks++; if (ir_pc !== 6'd12)  begin errors++; $display("FAIL halt_ir_pc got=%0d exp=12", ir_pc); end
    for (int i = 0; i < 4; i++) begin
      jump_en = 1; target = 6'd5; stall = 1'($urandom_range(0, 1));
      tick();
      checks++; if (address !== 6'd12) begin errors++; $display("FAIL halt_hold%0d got=%0d exp=12", i, address); end
      checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL halt_valid%0d got=%0b exp=0", i, ir_valid); end
    end
    idle();
    resume = 1;
    tick(); idle();
    checks++; if (halted !== 1'b0)   begin errors++; $display("FAIL resume got=%0b exp=0", halted); end
    checks++; if (address !== 6'd12) begin errors++; $display("FAIL resume_pc got=%0d exp=12", address); end
    tick();
    checks++; if (ir_pc !== 6'd12)   begin errors++; $display("FAIL restart_ir_pc got=%0d exp=12", ir_pc); end
    checks++; if (address !== 6'd13) begin errors++; $display("FAIL restart_pc got=%0d exp=13", address); end
    halt_en = 1; resume = 1;
    tick(); idle();
    checks++; if (halted !== 1'b1)   begin errors++; $display("FAIL halt_beats_resume got=%0b exp=1", halted); end
    tick();
    #2;
    reset = 1;
    #1;
    checks++; if (address !== 6'd0)  begin errors++; $display("FAIL async_address got=%0d exp=0", address); end
    checks++; if (ir !== 25'd0)      begin errors++; $display("FAIL async_ir got=%0h exp=0", ir); end
    checks++; if (ir_pc !== 6'd0)    begin errors++; $display("FAIL async_ir_pc got=%0d exp=0", ir_pc); end
    checks++; if (halted !== 1'b0)   begin errors++; $display("FAIL async_halted got=%0b exp=0", halted); end
    checks++; if ({ir_valid, stk_ovf, stk_unf} !== 3'b000) begin errors++; $display("FAIL async_flags got=%b exp=000", {ir_valid, stk_ovf, stk_unf}); end
    model_reset();
    #1;
    reset = 0;
  endtask

  task automatic test_random();
    idle();
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
    for (int n = 0; n < 400; n++) begin
      stall      = ($urandom_range(0, 7) == 0);
      halt_en    = ($urandom_range(0, 15) == 0);
      resume     = ($urandom_range(0, 3) == 0);
      ret_en     = ($urandom_range(0, 4) == 0);
      call_en    = ($urandom_range(0, 3) == 0);
      jump_en    = ($urandom_range(0, 4) == 0);
      branch_en  = ($urandom_range(0, 2) == 0);
      branch_off = 6'($urandom);
      target     = 6'($urandom);
      tick();
      checks++; if (address !== 6'(m_pc))   begin errors++; $display("FAIL rnd_address n=%0d got=%0d exp=%0d", n, address, m_pc); end
      checks++; if (ir !== m_ir)            begin errors++; $display("FAIL rnd_ir n=%0d got=%0h exp=%0h", n, ir, m_ir); end
      checks++; if (ir_pc !== 6'(m_irpc))   begin errors++; $display("FAIL rnd_ir_pc n=%0d got=%0d exp=%0d", n, ir_pc, m_irpc); end
      checks++; if (ir_valid !== m_valid)   begin errors++; $display("FAIL rnd_ir_valid n=%0d got=%0b exp=%0b", n, ir_valid, m_valid); end
      checks++; if (halted !== m_halted)    begin errors++; $display("FAIL rnd_halted n=%0d got=%0b exp=%0b", n, halted, m_halted); end
      checks++; if (stk_ovf !== m_ovf)      begin errors++; $display("FAIL rnd_ovf n=%0d got=%0b exp=%0b", n, stk_ovf, m_ovf); end
      checks++; if (stk_unf !== m_unf)      begin errors++; $display("FAIL rnd_unf n=%0d got=%0b exp=%0b", n, stk_unf, m_unf); end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    idle();
    reset = 0;
    model_reset();
    #1;
    test_reset();
    test_free_run();
    test_branch();
    test_call_ret();
    test_overflow();
    test_stall();
    test_halt();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
